// File: rtl/systolic_accum_buffer.sv
// systolic_accum_buffer: multi-tile output accumulator behind the systolic array.
// Each pass takes ROWS result rows of N_SIZE signed lanes. The first tile of a pass
// sequence overwrites the stored rows; later tiles add into them. After the last tile
// the rows are served through a 1-cycle read port.
// Optional build macro: ACC_SAT_EN (saturating accumulate with sticky overflow flag).
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for pass_start; reads served when result_ready
// ACCUM  | accepting rows, one per in_valid beat
// DRAIN  | last beat in flight through the write stage
module systolic_accum_buffer #(
   parameter int N_SIZE    = 32,
   parameter int IN_WIDTH  = 32,
   parameter int ACC_WIDTH = 32,
   parameter int ROWS      = 512,
   localparam int ADDR_WIDTH = $clog2(ROWS)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          pass_start,
   input  logic                          first_tile,
   input  logic                          last_tile,
   input  logic                          in_valid,
   input  logic [N_SIZE*IN_WIDTH-1:0]    in_data,
   output logic                          busy,
   output logic                          done,
   output logic                          result_ready,
   input  logic                          rd_en,
   input  logic [ADDR_WIDTH-1:0]         rd_addr,
   output logic [N_SIZE*ACC_WIDTH-1:0]   rd_data,
   output logic                          rd_valid,
   output logic                          overflow
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ACCUM = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   localparam logic [ADDR_WIDTH-1:0] ROW_LAST = ADDR_WIDTH'(ROWS - 1);

   logic [N_SIZE*ACC_WIDTH-1:0] mem [ROWS];

   state_t                      state_q, state_d;
   logic [ADDR_WIDTH-1:0]       row_q, row_d;
   logic                        first_q, first_d;
   logic                        last_q, last_d;
   logic                        s1_valid_q, s1_valid_d;
   logic [ADDR_WIDTH-1:0]       s1_row_q, s1_row_d;
   logic                        done_q, done_d;
   logic                        result_ready_q, result_ready_d;
   logic                        rd_valid_q, rd_valid_d;
   logic                        overflow_q, overflow_d;
   logic [N_SIZE*IN_WIDTH-1:0]  s1_in_q;
   logic [N_SIZE*ACC_WIDTH-1:0] s1_old_q;
   logic [N_SIZE*ACC_WIDTH-1:0] rd_data_q;

   logic                        accept;
   logic                        rd_accept;
   logic [ADDR_WIDTH-1:0]       rd_row;
   logic [N_SIZE*ACC_WIDTH-1:0] wr_data;
   logic                        clamp_any;
   logic signed [IN_WIDTH-1:0]  in_lane;
   logic signed [ACC_WIDTH-1:0] in_ext;
   logic signed [ACC_WIDTH-1:0] old_lane;
   logic signed [ACC_WIDTH-1:0] sum_lane;

   assign accept    = (state_q == S_ACCUM) && in_valid;
   assign rd_accept = rd_en && (state_q == S_IDLE) && result_ready_q;

   // Out-of-range read addresses fold onto row 0; a power-of-two depth has none.
   if ((1 << ADDR_WIDTH) == ROWS) begin : g_full_addr
      assign rd_row = rd_addr;
   end else begin : g_part_addr
      assign rd_row = (rd_addr < ADDR_WIDTH'(ROWS)) ? rd_addr : '0;
   end

   // Write-stage lane arithmetic: overwrite on the first tile, otherwise add.
   always_comb begin
      wr_data   = '0;
      clamp_any = 1'b0;
      in_lane   = '0;
      in_ext    = '0;
      old_lane  = '0;
      sum_lane  = '0;
      for (int i = 0; i < N_SIZE; i++) begin
         in_lane  = s1_in_q[i*IN_WIDTH +: IN_WIDTH];
         in_ext   = ACC_WIDTH'(in_lane);
         old_lane = first_q ? '0 : s1_old_q[i*ACC_WIDTH +: ACC_WIDTH];
         sum_lane = old_lane + in_ext;
`ifdef ACC_SAT_EN
         // Signed overflow only when both operands share a sign the result lost.
         if ((old_lane[ACC_WIDTH-1] == in_ext[ACC_WIDTH-1]) &&
             (sum_lane[ACC_WIDTH-1] != in_ext[ACC_WIDTH-1])) begin
            clamp_any = 1'b1;
            sum_lane  = in_ext[ACC_WIDTH-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                            : {1'b0, {(ACC_WIDTH-1){1'b1}}};
         end
`endif
         wr_data[i*ACC_WIDTH +: ACC_WIDTH] = sum_lane;
      end
   end

   // Next-state, row counter, handshake flags.
   always_comb begin
      state_d        = state_q;
      row_d          = row_q;
      first_d        = first_q;
      last_d         = last_q;
      s1_valid_d     = accept;
      s1_row_d       = accept ? row_q : s1_row_q;
      done_d         = 1'b0;
      result_ready_d = result_ready_q;
      rd_valid_d     = rd_accept;
      overflow_d     = overflow_q | (s1_valid_q & clamp_any);
      case (state_q)
         S_IDLE: begin
            if (pass_start) begin
               state_d        = S_ACCUM;
               first_d        = first_tile;
               last_d         = last_tile;
               row_d          = '0;
               result_ready_d = 1'b0;
               if (first_tile) overflow_d = 1'b0;
            end
         end
         S_ACCUM: begin
            if (accept) begin
               if (row_q == ROW_LAST) begin
                  state_d = S_DRAIN;
                  row_d   = '0;
               end else begin
                  row_d = row_q + 1'b1;
               end
            end
         end
         S_DRAIN: begin
            if (s1_valid_q) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
               if (last_q) result_ready_d = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Control registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= S_IDLE;
         row_q          <= '0;
         first_q        <= 1'b0;
         last_q         <= 1'b0;
         s1_valid_q     <= 1'b0;
         s1_row_q       <= '0;
         done_q         <= 1'b0;
         result_ready_q <= 1'b0;
         rd_valid_q     <= 1'b0;
         overflow_q     <= 1'b0;
      end else begin
         state_q        <= state_d;
         row_q          <= row_d;
         first_q        <= first_d;
         last_q         <= last_d;
         s1_valid_q     <= s1_valid_d;
         s1_row_q       <= s1_row_d;
         done_q         <= done_d;
         result_ready_q <= result_ready_d;
         rd_valid_q     <= rd_valid_d;
         overflow_q     <= overflow_d;
      end
   end

   // Row storage: stage 1 fetches the old row with the beat, stage 2 writes back.
   always_ff @(posedge clk) begin
      if (s1_valid_q && !rst) mem[s1_row_q] <= wr_data;
      if (accept) begin
         s1_in_q  <= in_data;
         s1_old_q <= mem[row_q];
      end
   end

   // Read port: data holds until the next accepted read.
   always_ff @(posedge clk) begin
      if (rst)            rd_data_q <= '0;
      else if (rd_accept) rd_data_q <= mem[rd_row];
   end

   assign busy         = (state_q != S_IDLE);
   assign done         = done_q;
   assign result_ready = result_ready_q;
   assign rd_data      = rd_data_q;
   assign rd_valid     = rd_valid_q;
   assign overflow     = overflow_q;

endmodule
